// File: rtl/aes_ui_pkg.sv
// Shared types and constants for the hex keypad entry block.
package aes_ui_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    ACCEPT   = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam int DIGITS = 4;

  // Indexed by {row, col}; entry 0 is the top-left key.
  localparam logic [0:15][3:0] KEYMAP = {
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    return KEYMAP[{row, col}];
  endfunction

  // Lowest-indexed active-low row wins when several keys share a column.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows_n);
    if (!rows_n[0])      return 2'd0;
    else if (!rows_n[1]) return 2'd1;
    else if (!rows_n[2]) return 2'd2;
    else                 return 2'd3;
  endfunction

endpackage

// File: rtl/input_sync.sv
// Two-flop synchronizer; with EDGE set, the output is a one-cycle rising-edge pulse
// of the synchronized signal instead of its level.
module input_sync #(
  parameter int           W       = 1,
  parameter bit           EDGE    = 1'b0,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] out_o
);

  logic [W-1:0] s1_q, s1_d, s2_q, s2_d;

  always_comb begin
    s1_d = async_i;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  if (EDGE) begin : g_edge
    logic [W-1:0] s3_q;
    always_ff @(posedge clk) begin
      if (rst) s3_q <= RST_VAL;
      else     s3_q <= s2_q;
    end
    assign out_o = s2_q & ~s3_q;
  end else begin : g_level
    assign out_o = s2_q;
  end

endmodule

// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner/debouncer assembling four key presses into a 16-bit word.
// Define AUTO_COMMIT_EN to commit automatically on the fourth digit (btn_enter unused).
module hex_keypad_entry
  import aes_ui_pkg::*;
#(
  parameter int SETTLE_CYC   = 1000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_n,
  input  logic        btn_clear,
  input  logic        btn_enter,
  output logic [3:0]  col_n,
  output logic [15:0] entry_value,
  output logic [2:0]  digit_count,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] commit_value,
  output logic        commit
);

  localparam int CNT_MAX = (SETTLE_CYC > DEBOUNCE_CYC) ? SETTLE_CYC : DEBOUNCE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [2:0]       FULL        = 3'(DIGITS);

  logic [3:0] rows_sync;
  logic       clear_pulse;

  input_sync #(.W(4), .EDGE(1'b0), .RST_VAL(4'hF)) u_row_sync (
    .clk(clk), .rst(rst), .async_i(row_n), .out_o(rows_sync)
  );
  input_sync #(.W(1), .EDGE(1'b1), .RST_VAL(1'b0)) u_clear_sync (
    .clk(clk), .rst(rst), .async_i(btn_clear), .out_o(clear_pulse)
  );
`ifndef AUTO_COMMIT_EN
  logic enter_pulse;
  input_sync #(.W(1), .EDGE(1'b1), .RST_VAL(1'b0)) u_enter_sync (
    .clk(clk), .rst(rst), .async_i(btn_enter), .out_o(enter_pulse)
  );
`endif

  state_e           state_q, state_d;
  logic [1:0]       col_q, col_d, row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      entry_q, entry_d, commit_value_q, commit_value_d;
  logic [2:0]       count_q, count_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d, commit_q, commit_d;
  logic [3:0]       key_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= SCAN;
      col_q          <= 2'd0;
      row_q          <= 2'd0;
      cnt_q          <= '0;
      entry_q        <= 16'h0;
      count_q        <= 3'd0;
      key_valid_q    <= 1'b0;
      key_code_q     <= 4'h0;
      commit_value_q <= 16'h0;
      commit_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      row_q          <= row_d;
      cnt_q          <= cnt_d;
      entry_q        <= entry_d;
      count_q        <= count_d;
      key_valid_q    <= key_valid_d;
      key_code_q     <= key_code_d;
      commit_value_q <= commit_value_d;
      commit_q       <= commit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    case (state_q)
      SCAN: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          if (rows_sync != 4'hF) begin
            row_d   = lowest_low_row(rows_sync);
            state_d = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DEBOUNCE: begin
        if (!rows_sync[row_q]) begin
          if (cnt_q == DEB_LAST) begin
            cnt_d   = '0;
            state_d = ACCEPT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      ACCEPT: begin
        cnt_d   = '0;
        state_d = RELEASE;
      end
      default: begin
        // RELEASE: any low row restarts the quiet-period count.
        if (&rows_sync) begin
          if (cnt_q == DEB_LAST) begin
            cnt_d   = '0;
            state_d = SCAN;
            col_d   = col_q + 2'd1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
    endcase
  end

  // Datapath: later assignments override earlier ones, giving clear > enter > store.
  always_comb begin
    col_n          = ~(4'b0001 << col_q);
    key_now        = key_lookup(row_q, col_q);
    entry_d        = entry_q;
    count_d        = count_q;
    key_valid_d    = 1'b0;
    key_code_d     = key_code_q;
    commit_value_d = commit_value_q;
    commit_d       = 1'b0;
    if (state_q == ACCEPT) begin
      key_valid_d = 1'b1;
      key_code_d  = key_now;
      if (count_q < FULL) begin
        entry_d = {entry_q[11:0], key_now};
        count_d = count_q + 3'd1;
      end
`ifdef AUTO_COMMIT_EN
      if (count_q == FULL - 3'd1) begin
        commit_d       = 1'b1;
        commit_value_d = {entry_q[11:0], key_now};
        entry_d        = 16'h0;
        count_d        = 3'd0;
      end
`endif
    end
`ifndef AUTO_COMMIT_EN
    if (enter_pulse && count_q == FULL) begin
      commit_d       = 1'b1;
      commit_value_d = entry_q;
      entry_d        = 16'h0;
      count_d        = 3'd0;
    end
`endif
    if (clear_pulse) begin
      entry_d        = 16'h0;
      count_d        = 3'd0;
      commit_d       = 1'b0;
      commit_value_d = commit_value_q;
    end
  end

  assign entry_value  = entry_q;
  assign digit_count  = count_q;
  assign key_valid    = key_valid_q;
  assign key_code     = key_code_q;
  assign commit_value = commit_value_q;
  assign commit       = commit_q;

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Directed bench for hex_keypad_entry with a behavioural keypad driving row_n.
module tb_hex_keypad_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_n;
  logic        btn_clear, btn_enter;
  logic [3:0]  col_n;
  logic [15:0] entry_value, commit_value;
  logic [2:0]  digit_count;
  logic        key_valid, commit;
  logic [3:0]  key_code;

  int checks = 0;
  int failures = 0;
  int kv_cnt = 0;
  int commit_cnt = 0;
  logic [3:0]  last_code = 4'h0;
  logic [15:0] last_commit = 16'h0;

  logic       key_down = 1'b0;
  logic [1:0] key_r = 2'd0, key_c = 2'd0;

  localparam logic [63:0] MAP_ROWS = 64'h123A_456B_789C_0FED;

  always #5 clk = ~clk;

  hex_keypad_entry #(.SETTLE_CYC(4), .DEBOUNCE_CYC(16)) dut (
    .clk(clk), .rst(rst), .row_n(row_n), .btn_clear(btn_clear), .btn_enter(btn_enter),
    .col_n(col_n), .entry_value(entry_value), .digit_count(digit_count),
    .key_valid(key_valid), .key_code(key_code), .commit_value(commit_value), .commit(commit)
  );

  // A pressed key pulls its row low only while its column is driven.
  always_comb begin
    row_n = 4'hF;
    if (key_down && !col_n[key_c]) row_n[key_r] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid) begin
      kv_cnt    = kv_cnt + 1;
      last_code = key_code;
    end
    if (commit) begin
      commit_cnt  = commit_cnt + 1;
      last_commit = commit_value;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_key(input logic [3:0] code);
    logic [63:0] m;
    m = MAP_ROWS;
    for (int i = 0; i < 16; i++) begin
      if (m[63-4*i -: 4] == code) begin
        key_r = 2'(i / 4);
        key_c = 2'(i % 4);
      end
    end
  endtask

  task automatic press(input logic [3:0] code);
    set_key(code);
    key_down = 1'b1;
    tick(60);
    key_down = 1'b0;
    tick(40);
  endtask

  task automatic pulse_btn(input bit is_clear);
    if (is_clear) btn_clear = 1'b1; else btn_enter = 1'b1;
    tick(4);
    btn_clear = 1'b0;
    btn_enter = 1'b0;
    tick(4);
  endtask

  task automatic wait_kv(input string tag);
    int n;
    n = 0;
    while (key_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 16'(key_valid), 16'd1);
  endtask

  // Returns on the first negedge after the scanner moves onto the target column.
  task automatic sync_to_col(input logic [3:0] target);
    int n;
    n = 0;
    while (col_n == target && n < 100) begin @(negedge clk); n++; end
    while (col_n != target && n < 200) begin @(negedge clk); n++; end
    chk("col_sync", 16'(col_n), 16'(target));
  endtask

  int kv0;

  initial begin
    rst = 1'b1; btn_clear = 1'b0; btn_enter = 1'b0;
    tick(3);
    chk("rst_col_n", 16'(col_n), 16'hE);
    chk("rst_entry", entry_value, 16'h0);
    chk("rst_count", 16'(digit_count), 16'd0);
    chk("rst_key_valid", 16'(key_valid), 16'd0);
    chk("rst_key_code", 16'(key_code), 16'd0);
    chk("rst_commit_value", commit_value, 16'h0);
    chk("rst_commit", 16'(commit), 16'd0);
    rst = 1'b0;
    tick(2);

    // Clean press of r0c3 held 40 cycles.
    kv0 = kv_cnt;
    set_key(4'hA);
    key_down = 1'b1;
    tick(40);
    key_down = 1'b0;
    tick(40);
    chk("a_kv_count", 16'(kv_cnt - kv0), 16'd1);
    chk("a_code", 16'(last_code), 16'hA);
    chk("a_entry", entry_value, 16'h000A);
    chk("a_count", 16'(digit_count), 16'd1);

    pulse_btn(1'b1);
    chk("clear_entry", entry_value, 16'h0);
    chk("clear_count", 16'(digit_count), 16'd0);

`ifndef AUTO_COMMIT_EN
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    chk("1234_entry", entry_value, 16'h1234);
    chk("1234_count", 16'(digit_count), 16'd4);
    pulse_btn(1'b0);
    chk("enter_commit_cnt", 16'(commit_cnt), 16'd1);
    chk("enter_commit_pulse_val", last_commit, 16'h1234);
    chk("enter_commit_value", commit_value, 16'h1234);
    chk("enter_entry", entry_value, 16'h0);
    chk("enter_count", 16'(digit_count), 16'd0);

    // Key 5 bouncing 3 low / 2 high four times, then stable.
    kv0 = kv_cnt;
    set_key(4'h5);
    for (int i = 0; i < 4; i++) begin
      key_down = 1'b1; tick(3);
      key_down = 1'b0; tick(2);
    end
    key_down = 1'b1; tick(60);
    key_down = 1'b0; tick(40);
    chk("bounce_kv_count", 16'(kv_cnt - kv0), 16'd1);
    chk("bounce_code", 16'(last_code), 16'h5);
    chk("bounce_entry", entry_value, 16'h0005);

    press(4'h6); press(4'h7); press(4'h8);
    chk("5678_entry", entry_value, 16'h5678);
    kv0 = kv_cnt;
    press(4'h9);
    chk("sat_kv_count", 16'(kv_cnt - kv0), 16'd1);
    chk("sat_code", 16'(last_code), 16'h9);
    chk("sat_entry", entry_value, 16'h5678);
    chk("sat_count", 16'(digit_count), 16'd4);

    pulse_btn(1'b1);
    press(4'h1); press(4'h2);
    pulse_btn(1'b0);
    chk("enter2_no_commit", 16'(commit_cnt), 16'd1);
    chk("enter2_entry", entry_value, 16'h0012);
    chk("enter2_count", 16'(digit_count), 16'd2);
`else
    press(4'hD); press(4'hE); press(4'hA);
    set_key(4'hD);
    key_down = 1'b1;
    wait_kv("dead_kv");
    chk("dead_commit", 16'(commit), 16'd1);
    chk("dead_commit_value", commit_value, 16'hDEAD);
    chk("dead_entry", entry_value, 16'h0);
    chk("dead_count", 16'(digit_count), 16'd0);
    tick(20);
    key_down = 1'b0;
    tick(40);
`endif

    // Clear edge lands in the ACCEPT cycle of key 9 (r2c2): press as column 2 starts,
    // detection 4 cycles later, 16 debounce cycles, clear pin raised 3 cycles ahead.
    set_key(4'h9);
    sync_to_col(4'b1011);
    key_down = 1'b1;
    tick(18);
    btn_clear = 1'b1;
    wait_kv("clr_acc_kv");
    chk("clr_acc_code", 16'(key_code), 16'h9);
    chk("clr_acc_entry", entry_value, 16'h0);
    chk("clr_acc_count", 16'(digit_count), 16'd0);
    tick(4);
    btn_clear = 1'b0;
    tick(20);
    key_down = 1'b0;
    tick(40);

    // Reset while key C (r2c3) is being debounced.
    set_key(4'hC);
    sync_to_col(4'b0111);
    key_down = 1'b1;
    tick(10);
    rst = 1'b1;
    tick(1);
    chk("rstmid_col_n", 16'(col_n), 16'hE);
    chk("rstmid_entry", entry_value, 16'h0);
    chk("rstmid_count", 16'(digit_count), 16'd0);
    chk("rstmid_key_valid", 16'(key_valid), 16'd0);
    chk("rstmid_key_code", 16'(key_code), 16'd0);
    chk("rstmid_commit_value", commit_value, 16'h0);
    chk("rstmid_commit", 16'(commit), 16'd0);
    rst = 1'b0;
    wait_kv("redetect_kv");
    chk("redetect_code", 16'(key_code), 16'hC);
    chk("redetect_entry", entry_value, 16'h000C);
    tick(10);
    key_down = 1'b0;
    tick(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
